// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared line-transfer port between icache and dcache misses.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; otherwise dcache always wins.
module cache_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_addr,
  output logic        ic_gnt,
  output logic [31:0] ic_rd_data [0:7],
  input  logic        dc_rd_req,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wr_data [0:7],
  output logic        dc_gnt,
  output logic [31:0] dc_rd_data [0:7],
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata [0:7],
  input  logic [31:0] mem_rdata [0:7],
  input  logic        mem_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = dcache
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q [0:7];
  logic [31:0] mem_wdata_d [0:7];
  logic        ic_gnt_q, ic_gnt_d;
  logic        dc_gnt_q, dc_gnt_d;
  logic [31:0] ic_rd_data_q [0:7];
  logic [31:0] ic_rd_data_d [0:7];
  logic [31:0] dc_rd_data_q [0:7];
  logic [31:0] dc_rd_data_d [0:7];

  logic dc_any_s, req_any_s, pick_dc_s, dc_write_s;
  logic unused_addr_bits_s;

  assign dc_any_s   = dc_rd_req | dc_wr_req;
  assign req_any_s  = dc_any_s | ic_rd_req;
  assign dc_write_s = pick_dc_s & dc_wr_req;
  assign unused_addr_bits_s = ^{ic_addr[4:0], dc_addr[4:0]};

`ifdef CACHE_ARB_RR_EN
  logic last_q, last_d;  // last owner, 1 = dcache
  assign pick_dc_s = dc_any_s & (~ic_rd_req | ~last_q);
`else
  assign pick_dc_s = dc_any_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any_s) state_d = BUSY; else state_d = IDLE;
      BUSY:    if (mem_done)  state_d = RESP; else state_d = BUSY;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and latched transfer
  always_comb begin
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ic_gnt_d     = 1'b0;
    dc_gnt_d     = 1'b0;
    ic_rd_data_d = ic_rd_data_q;
    dc_rd_data_d = dc_rd_data_q;
`ifdef CACHE_ARB_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any_s) begin
          owner_d   = pick_dc_s;
          mem_req_d = 1'b1;
          mem_we_d  = dc_write_s;
`ifdef CACHE_ARB_RR_EN
          last_d    = pick_dc_s;
`endif
          if (pick_dc_s) begin
            mem_addr_d = {dc_addr[31:5], 5'd0};
          end else begin
            mem_addr_d = {ic_addr[31:5], 5'd0};
          end
          if (dc_write_s) begin
            mem_wdata_d = dc_wr_data;
          end else begin
            mem_wdata_d = '{default: 32'd0};
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      BUSY: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q) begin
            dc_gnt_d = 1'b1;
          end else begin
            ic_gnt_d = 1'b1;
          end
          // Read data is only valid in the done cycle; writes leave both buffers alone
          if (!mem_we_q && owner_q) begin
            dc_rd_data_d = mem_rdata;
          end else if (!mem_we_q) begin
            ic_rd_data_d = mem_rdata;
          end else begin
            dc_rd_data_d = dc_rd_data_q;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      RESP:    mem_req_d = 1'b0;
      default: mem_req_d = 1'b0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= '{default: 32'd0};
      ic_gnt_q     <= 1'b0;
      dc_gnt_q     <= 1'b0;
      ic_rd_data_q <= '{default: 32'd0};
      dc_rd_data_q <= '{default: 32'd0};
`ifdef CACHE_ARB_RR_EN
      last_q       <= 1'b0;
`endif
    end else begin
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_gnt_q     <= ic_gnt_d;
      dc_gnt_q     <= dc_gnt_d;
      ic_rd_data_q <= ic_rd_data_d;
      dc_rd_data_q <= dc_rd_data_d;
`ifdef CACHE_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign ic_gnt     = ic_gnt_q;
  assign dc_gnt     = dc_gnt_q;
  assign ic_rd_data = ic_rd_data_q;
  assign dc_rd_data = dc_rd_data_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter (both tie-break builds).
module tb_cache_mem_arbiter;

  typedef logic [31:0] line_t [0:7];

  typedef struct {
    logic        ic;
    logic        dcr;
    logic        dcw;
    logic [31:0] ica;
    logic [31:0] dca;
    logic [31:0] wseed;
    logic [31:0] rseed;
    int          done_cyc;
    logic        drop;
    logic        exp_dc;
    logic        exp_we;
    logic [31:0] exp_addr;
  } vec_t;

`ifdef CACHE_ARB_RR_EN
  localparam logic RR_TIE = 1'b1;
`else
  localparam logic RR_TIE = 1'b0;
`endif
  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd_req, dc_rd_req, dc_wr_req, mem_done;
  logic [31:0] ic_addr, dc_addr;
  logic        ic_gnt, dc_gnt, mem_req, mem_we;
  logic [31:0] mem_addr;
  line_t       ic_rd_data, dc_rd_data, dc_wr_data, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t  tbl [NV];
  vec_t  v;
  line_t zero, exp_ic, exp_dc, exp_w;
  int    n;
  logic  idle_ok, busy_ok;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rd_data(ic_rd_data),
    .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr),
    .dc_wr_data(dc_wr_data), .dc_gnt(dc_gnt), .dc_rd_data(dc_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  function automatic line_t pat(input logic [31:0] seed);
    for (int k = 0; k < 8; k++) pat[k] = seed + 32'(k);
  endfunction

  function automatic vec_t mk(input logic ic, input logic dcr, input logic dcw,
                              input logic [31:0] ica, input logic [31:0] dca,
                              input logic [31:0] wseed, input logic [31:0] rseed,
                              input int done_cyc, input logic drop, input logic exp_dc,
                              input logic exp_we, input logic [31:0] exp_addr);
    mk.ic = ic; mk.dcr = dcr; mk.dcw = dcw; mk.ica = ica; mk.dca = dca;
    mk.wseed = wseed; mk.rseed = rseed; mk.done_cyc = done_cyc; mk.drop = drop;
    mk.exp_dc = exp_dc; mk.exp_we = exp_we; mk.exp_addr = exp_addr;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input line_t act, input line_t exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = 0; k < 8; k++) if (act[k] !== exp[k] && bad < 0) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s word %0d: got %h, expected %h", name, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic apply(input vec_t r);
    ic_rd_req  = r.ic;
    dc_rd_req  = r.dcr;
    dc_wr_req  = r.dcw;
    ic_addr    = r.ica;
    dc_addr    = r.dca;
    dc_wr_data = pat(r.wseed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Ties alternate dc, ic, dc, ic under round-robin; fixed priority serves ic once dc is gone.
    tbl[0] = mk(1'b1, 1'b0,   1'b0, 32'hBFC0_0014, 32'h0000_0000, 32'h1111_0000, 32'h0000_0001, 5, 1'b0, 1'b0, 1'b0, 32'hBFC0_0000);
    tbl[1] = mk(1'b1, 1'b1,   1'b0, 32'h0000_1008, 32'h0000_2010, 32'h2222_0000, 32'hA100_0000, 3, 1'b0, 1'b1, 1'b0, 32'h0000_2000);
    tbl[2] = mk(1'b1, RR_TIE, 1'b0, 32'h0000_3018, 32'h0000_4000, 32'h3333_0000, 32'hA200_0000, 2, 1'b0, 1'b0, 1'b0, 32'h0000_3000);
    tbl[3] = mk(1'b1, 1'b1,   1'b0, 32'h0000_5000, 32'h0000_6004, 32'h4444_0000, 32'hA300_0000, 4, 1'b0, 1'b1, 1'b0, 32'h0000_6000);
    tbl[4] = mk(1'b1, RR_TIE, 1'b0, 32'h0000_7000, 32'h0000_8000, 32'h4545_0000, 32'hA400_0000, 2, 1'b0, 1'b0, 1'b0, 32'h0000_7000);
    tbl[5] = mk(1'b0, 1'b0,   1'b1, 32'h0000_0000, 32'h8000_1020, 32'h5555_0000, 32'hA500_0000, 3, 1'b0, 1'b1, 1'b1, 32'h8000_1020);
    tbl[6] = mk(1'b0, 1'b1,   1'b0, 32'h0000_0000, 32'h8000_2040, 32'h6666_0000, 32'hA600_0000, 2, 1'b1, 1'b1, 1'b0, 32'h8000_2040);
    tbl[7] = mk(1'b0, 1'b1,   1'b1, 32'h0000_0000, 32'h1234_567F, 32'h7777_0000, 32'hA700_0000, 2, 1'b0, 1'b1, 1'b1, 32'h1234_5660);
    tbl[8] = mk(1'b1, 1'b0,   1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8888_0000, 32'hA800_0000, 1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFE0);

    zero = '{default: 32'd0};
    rst = 1'b1;
    ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0; mem_done = 1'b0;
    ic_addr = 32'd0; dc_addr = 32'd0; dc_wr_data = zero; mem_rdata = zero;
    repeat (3) @(negedge clk);

    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_gnt", {30'd0, ic_gnt, dc_gnt}, 32'd0);
    chk_line("rst_mem_wdata", mem_wdata, zero);
    chk_line("rst_ic_buf", ic_rd_data, zero);
    chk_line("rst_dc_buf", dc_rd_data, zero);
    rst = 1'b0;
    @(negedge clk);

    // mem_done while idle must be ignored
    mem_done = 1'b1; mem_rdata = pat(32'h5A5A_0000);
    @(negedge clk);
    mem_done = 1'b0;
    chk("idle_done_gnt", {30'd0, ic_gnt, dc_gnt}, 32'd0);
    chk_line("idle_done_ic_buf", ic_rd_data, zero);
    chk_line("idle_done_dc_buf", dc_rd_data, zero);
    @(negedge clk);
    chk("idle_done_mem_req", {31'd0, mem_req}, 32'd0);

    exp_ic = zero;
    exp_dc = zero;
    apply(tbl[0]);
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      n = 0;
      idle_ok = 1'b1;
      do begin
        @(negedge clk);
        n++;
        if (ic_gnt || dc_gnt) idle_ok = 1'b0;
      end while (!mem_req && n < 8);
      chk($sformatf("v%0d_req_latency", i), 32'(n), (i == 0) ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_gnt_single_pulse", i), {31'd0, idle_ok}, 32'd1);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v.exp_addr);
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, v.exp_we});
      if (v.exp_we) exp_w = pat(v.wseed); else exp_w = zero;
      chk_line($sformatf("v%0d_mem_wdata", i), mem_wdata, exp_w);
      if (v.drop) begin
        ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      end
      busy_ok = 1'b1;
      repeat (v.done_cyc - 1) begin
        @(negedge clk);
        if (!mem_req || ic_gnt || dc_gnt) busy_ok = 1'b0;
      end
      chk($sformatf("v%0d_busy_hold", i), {31'd0, busy_ok}, 32'd1);
      mem_done = 1'b1;
      mem_rdata = pat(v.rseed);
      @(negedge clk);
      mem_done = 1'b0;
      mem_rdata = pat(32'hDEAD_0000);
      chk($sformatf("v%0d_ic_gnt", i), {31'd0, ic_gnt}, {31'd0, ~v.exp_dc});
      chk($sformatf("v%0d_dc_gnt", i), {31'd0, dc_gnt}, {31'd0, v.exp_dc});
      chk($sformatf("v%0d_req_drop", i), {31'd0, mem_req}, 32'd0);
      if (!v.exp_we && v.exp_dc) exp_dc = pat(v.rseed);
      if (!v.exp_we && !v.exp_dc) exp_ic = pat(v.rseed);
      chk_line($sformatf("v%0d_ic_buf", i), ic_rd_data, exp_ic);
      chk_line($sformatf("v%0d_dc_buf", i), dc_rd_data, exp_dc);
      if (i + 1 < NV) begin
        apply(tbl[i + 1]);
      end else begin
        ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      end
    end

    // Reset in the middle of a transfer
    repeat (3) @(negedge clk);
    ic_rd_req = 1'b1; ic_addr = 32'h0000_9040;
    @(negedge clk);
    chk("rstx_req_up", {31'd0, mem_req}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1; ic_rd_req = 1'b0;
    @(negedge clk);
    chk("rstx_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstx_gnt", {30'd0, ic_gnt, dc_gnt}, 32'd0);
    chk("rstx_mem_addr", mem_addr, 32'd0);
    chk_line("rstx_ic_buf", ic_rd_data, zero);
    chk_line("rstx_dc_buf", dc_rd_data, zero);
    rst = 1'b0; dc_rd_req = 1'b1; dc_addr = 32'h0000_A0B5;
    @(negedge clk);
    chk("rstx_idle_req", {31'd0, mem_req}, 32'd1);
    chk("rstx_idle_addr", mem_addr, 32'h0000_A0A0);
    mem_done = 1'b1; mem_rdata = pat(32'h0000_0007);
    @(negedge clk);
    mem_done = 1'b0; dc_rd_req = 1'b0;
    chk("rstx_dc_gnt", {30'd0, ic_gnt, dc_gnt}, 32'd1);
    chk_line("rstx_dc_refill", dc_rd_data, pat(32'h0000_0007));
    @(negedge clk);
    chk("rstx_gnt_clear", {30'd0, ic_gnt, dc_gnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one cache-line transfer port to the AXI bridge between the instruction cache and the data cache. It latches the winning request and drives an 8-word line read or write downstream. When the line transfer finishes it pulses the requester's grant and holds the read line stable for the cache's refill cycle. It sits between the icache/dcache miss state machines and the AXI burst master.

## Interface
- Parameters: none; line size fixed at 8 × 32-bit words, line address aligned to 32 bytes.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `ic_rd_req`  in  1  icache line-read request; level, held until `ic_gnt`
- `ic_addr`  in  32  icache line address
- `ic_gnt`  out  1  one-cycle completion pulse to icache
- `ic_rd_data`  out  32 × [0:7]  line read for icache
- `dc_rd_req`  in  1  dcache line-read (refill) request; level
- `dc_wr_req`  in  1  dcache line-write (writeback) request; level
- `dc_addr`  in  32  dcache line address
- `dc_wr_data`  in  32 × [0:7]  writeback line
- `dc_gnt`  out  1  one-cycle completion pulse to dcache
- `dc_rd_data`  out  32 × [0:7]  line read for dcache
- `mem_req`  out  1  downstream transfer request; level
- `mem_we`  out  1  1 = line write, 0 = line read
- `mem_addr`  out  32  downstream line address, bits [4:0] forced to 0
- `mem_wdata`  out  32 × [0:7]  downstream write line
- `mem_rdata`  in  32 × [0:7]  downstream read line; valid only in the `mem_done` cycle
- `mem_done`  in  1  one-cycle transfer-complete pulse

## Operation
- FSM states:
  - `IDLE`: sample requests.
  - `BUSY`: transfer in flight.
  - `RESP`: grant pulse.
- `IDLE`:
  - If any request is present, choose an owner and latch the transfer into registers:
    - owner id;
    - `mem_addr = {addr[31:5], 5'b0}`;
    - `mem_we`: 1 only for a dcache write;
    - `mem_wdata = dc_wr_data` for a write, otherwise 0.
  - Then go to `BUSY`.
- dcache request type: if `dc_wr_req` and `dc_rd_req` are both high, write wins.
- Fixed priority (default): dcache beats icache.
- `BUSY`:
  - `mem_req = 1`; address, we and wdata come from the latched registers.
  - Requester inputs are ignored.
  - On `mem_done`, capture `mem_rdata` into the owner's read buffer (read transfers only) and go to `RESP`.
- `RESP`:
  - The owner's gnt = 1 for exactly this cycle.
  - Next state is `IDLE`; requests are not sampled in `RESP`.
- Read buffers:
  - `ic_rd_data` and `dc_rd_data` are separate registers.
  - Each is written only by a completed read for that owner and is held until that owner's next completed read.
  - A dcache write does not modify `dc_rd_data`.
- Outputs are registered; no combinational path from any `*_req` to any `mem_*` output or gnt.

## Timing
- Reset values:
  - state `IDLE`, owner = icache (for round-robin).
  - `mem_req`, `mem_we` = 0; `mem_addr` = 0; `mem_wdata` all 0.
  - `ic_gnt`, `dc_gnt` = 0.
  - `ic_rd_data`, `dc_rd_data` all 0.
- Latency:
  - Request first seen in `IDLE` at cycle 0 → `mem_req` high at cycle 1.
  - `mem_done` at cycle N → gnt at N+1; `mem_req` low from N+1.
  - `IDLE` at N+2; earliest next `mem_req` at N+3.
- The read buffer is valid from cycle N+1 onward. A cache that uses it in the cycle after gnt (N+2) sees stable data.
- Back-to-back dcache writeback then refill:
  - dcache raises `dc_rd_req` in the cycle after `dc_gnt`.
  - The arbiter samples it in `IDLE` (N+2) without a lost cycle.
- `mem_done` outside `BUSY` is ignored.
- `mem_done` in the first `BUSY` cycle (N = 1) is legal.
- A request dropped before grant: the latched transfer still completes and gnt still pulses.
- `rst` mid-transfer:
  - Return to `IDLE` next edge; `mem_req` drops; no gnt is issued.
  - The bridge shares `rst`.

## Configuration
- `CACHE_ARB_RR_EN` defined: round-robin between icache and dcache.
  - On a tie in `IDLE`, grant the requester that was not the last owner.
  - Last owner updates on each entry to `BUSY`; resets to icache, so the first tie goes to dcache.
- Undefined: fixed priority, dcache always wins ties; no last-owner register.

## Test plan
- Lone icache read, `ic_addr=0xBFC0_0014`:
  - `mem_addr=0xBFC0_0000`, `mem_we=0`, from cycle 1.
  - `mem_done` at cycle 5 with `mem_rdata[k]=k+1`.
  - `ic_gnt` at cycle 6 only; `ic_rd_data[k]=k+1` held until the next icache read.
- dcache writeback `0x8000_1020` then refill `0x8000_2040`:
  - `mem_we=1` with `mem_wdata` equal to `dc_wr_data`.
  - Second `mem_req` starts 3 cycles after the first `mem_done`.
  - `dc_rd_data` is unchanged by the write.
- Simultaneous `ic_rd_req` and `dc_rd_req` at cycle 0:
  - Default: dcache served first, icache second.
  - With `CACHE_ARB_RR_EN`, repeated ties alternate dc, ic, dc, ic.
- `dc_wr_req` and `dc_rd_req` both high → write transfer first (`mem_we=1`).
- `rst` asserted at cycle 3 of a transfer → `mem_req=0` and all gnt 0 at cycle 4; state `IDLE`.
- `mem_done` pulsed while `IDLE` → no gnt and no state change.
